pim_shift_accumulator: RTL and testbench

Output-side collector for the bit-serial PIM convolution datapath. Each compute beat delivers four ADC partial sums (HH, HL, LH, LL nibble products) for one crossbar column address. The block shift-and-adds these over INPUT_P/2 beats into a full-precision dot product. It saturates the result to OUT_P bits and queues it, tagged with its address, in a small FIFO behind a valid/ready output port.

---
 rtl/pim_shift_accumulator_pkg.sv | 49 ++++
 rtl/pim_shift_accumulator_if.sv | 43 ++++
 rtl/pim_shift_accumulator_fifo.sv | 107 ++++++++++
 rtl/pim_shift_accumulator.sv | 210 +++++++++++++++++++++
 tb/tb_pim_shift_accumulator.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_shift_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// pim_acc_pkg
// Shared definitions for the PIM shift-accumulator slice: the ceiling-log2
// helper, the derived-width functions used by every file, and the two-state
// collector FSM encoding.
// ---------------------------------------------------------------------------
package pim_acc_pkg;

  // Collector FSM: IDLE waits for a first beat, ACC is summing a result.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clogb2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    return result;
  endfunction

  // Beats per result: the input is consumed one half-width nibble bit at a time.
  function automatic int calc_half(input int input_p);
    return input_p / 32'sd2;
  endfunction

  // Accumulator width: largest term is HH shifted by up to 3*HALF-1, summed
  // over HALF beats, plus one carry bit, so it can never wrap.
  function automatic int calc_acc_w(input int adc_p, input int input_p);
    return adc_p + (32'sd3 * calc_half(input_p)) + 32'sd1;
  endfunction

  // Column address width, never narrower than one bit.
  function automatic int calc_addr_w(input int depth);
    return (clogb2(depth) > 32'sd1) ? clogb2(depth) : 32'sd1;
  endfunction

  // Beat counter width, never narrower than one bit.
  function automatic int calc_cnt_w(input int half);
    return (clogb2(half) > 32'sd1) ? clogb2(half) : 32'sd1;
  endfunction

endpackage

// File: rtl/pim_shift_accumulator_if.sv
// ---------------------------------------------------------------------------
// pim_shift_accumulator_if
// Beat input and result output bundle of the shift-accumulator.
//   in_valid/in_first/in_addr/psum_*  : compute beat from the ADC stage
//   out_valid/out_ready/out_*         : result queue head, valid/ready
//   busy/err/overflow                 : status
// The master side is the datapath/consumer environment, slave is the block.
// ---------------------------------------------------------------------------
interface pim_shift_accumulator_if #(
  parameter int ADDR_W = 1,
  parameter int ADC_P  = 4,
  parameter int OUT_P  = 16
) ();

  logic              in_valid;
  logic              in_first;
  logic [ADDR_W-1:0] in_addr;
  logic [ADC_P-1:0]  psum_hh;
  logic [ADC_P-1:0]  psum_hl;
  logic [ADC_P-1:0]  psum_lh;
  logic [ADC_P-1:0]  psum_ll;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_P-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_sat;
  logic              busy;
  logic              err;
  logic              overflow;

  modport master (
    output in_valid, in_first, in_addr, psum_hh, psum_hl, psum_lh, psum_ll,
    output out_ready,
    input  out_valid, out_data, out_addr, out_sat, busy, err, overflow
  );

  modport slave (
    input  in_valid, in_first, in_addr, psum_hh, psum_hl, psum_lh, psum_ll,
    input  out_ready,
    output out_valid, out_data, out_addr, out_sat, busy, err, overflow
  );

endinterface

// File: rtl/pim_shift_accumulator_fifo.sv
// ---------------------------------------------------------------------------
// pim_result_fifo
// Synchronous result queue with a registered head. Push and pop in the same
// cycle are accepted when full (the popped slot is reused) and when empty
// (the pushed word becomes the new head).
//   clk, rst        : clock, synchronous active-low reset
//   push_i/push_data_i : write request and word
//   pop_i           : remove head (ignored when empty)
//   full_o/empty_o  : occupancy flags
//   head_valid_o/head_data_o : registered head of queue
// ---------------------------------------------------------------------------
module pim_result_fifo
  import pim_acc_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             head_valid_o,
  output logic [WIDTH-1:0] head_data_o
);

  localparam int PTR_W = clogb2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Occupancy, pointer and next-head computation.
  always_comb begin
    pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});
    push_ok_s = push_i && ((count_q != CNT_MAX) || pop_ok_s);

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    head_valid_d = (count_d != {CNT_W{1'b0}});
    // The new head is the word written this cycle only when the queue
    // drains to it; otherwise it is already in storage.
    if (!head_valid_d) begin
      head_d = head_q;
    end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      head_q       <= {WIDTH{1'b0}};
      head_valid_q <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign full_o       = (count_q == CNT_MAX);
  assign empty_o      = (count_q == {CNT_W{1'b0}});
  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_q;

endmodule

// File: rtl/pim_shift_accumulator.sv
// ---------------------------------------------------------------------------
// pim_shift_accumulator
// Collects HALF beats of four nibble partial sums (HH, HL, LH, LL) per
// crossbar column, shift-adds them into a full dot product, saturates to
// OUT_P bits and queues {data, sat, addr} behind a valid/ready port.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of pim_shift_accumulator_if (beat input, result
//              output, busy/err/overflow status); its ADDR_W must equal
//              calc_addr_w(DEPTH) and its ADC_P/OUT_P the ones given here.
// ---------------------------------------------------------------------------
module pim_shift_accumulator
  import pim_acc_pkg::*;
#(
  parameter int INPUT_P    = 8,
  parameter int ADC_P      = 4,
  parameter int DEPTH      = 1,
  parameter int OUT_P      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  pim_shift_accumulator_if.slave bus
);

  localparam int HALF    = calc_half(INPUT_P);
  localparam int ACC_W   = calc_acc_w(ADC_P, INPUT_P);
  localparam int ADDR_W  = calc_addr_w(DEPTH);
  localparam int CNT_W   = calc_cnt_w(HALF);
  localparam int ENTRY_W = OUT_P + 1 + ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  acc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              busy_q;

  logic              start_s;
  logic              beat_ok_s;
  logic              last_s;
  logic [CNT_W-1:0]  b_eff_s;
  logic [ACC_W-1:0]  hh_ext_s, mid_ext_s, ll_ext_s;
  logic [ACC_W-1:0]  term_s;
  logic [ACC_W-1:0]  sum_s;
  logic              sat_s;
  logic [OUT_P-1:0]  sat_data_s;
  logic              push_s;
  logic [ADDR_W-1:0] push_addr_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [ENTRY_W-1:0] head_s;

  // Beat term: a first beat always counts as bit 0 and starts from an empty
  // accumulator, whichever state it arrives in.
  always_comb begin
    start_s = bus.in_valid && bus.in_first;
    if (start_s) begin
      b_eff_s = {CNT_W{1'b0}};
    end else begin
      b_eff_s = b_q;
    end
    last_s    = (b_eff_s == CNT_LAST);
    hh_ext_s  = ACC_W'(bus.psum_hh);
    mid_ext_s = ACC_W'(bus.psum_hl) + ACC_W'(bus.psum_lh);
    ll_ext_s  = ACC_W'(bus.psum_ll);
    term_s    = (hh_ext_s  << (int'(b_eff_s) + (32'sd2 * HALF)))
              + (mid_ext_s << (int'(b_eff_s) + HALF))
              + (ll_ext_s  <<  int'(b_eff_s));
    if (start_s) begin
      sum_s = term_s;
    end else begin
      sum_s = acc_q + term_s;
    end
  end

  // Saturation of the completed sum to OUT_P bits.
  always_comb begin
    sat_s = ((sum_s >> OUT_P) != {ACC_W{1'b0}});
    if (sat_s) begin
      sat_data_s = {OUT_P{1'b1}};
    end else begin
      sat_data_s = OUT_P'(sum_s);
    end
  end

  // Collector FSM next state, beat bookkeeping and result push.
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    acc_d       = acc_q;
    addr_d      = addr_q;
    err_d       = err_q;
    beat_ok_s   = 1'b0;
    push_s      = 1'b0;
    push_addr_s = addr_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // A continuation beat with no result open is dropped.
          if (bus.in_first) begin
            beat_ok_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          beat_ok_s = 1'b0;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          beat_ok_s = 1'b1;
          // Restart mid-result abandons the partial sum.
          if (bus.in_first) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          beat_ok_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        b_d     = {CNT_W{1'b0}};
        acc_d   = {ACC_W{1'b0}};
      end
    endcase

    if (beat_ok_s) begin
      if (start_s) begin
        addr_d = bus.in_addr;
      end else begin
        addr_d = addr_q;
      end
      push_addr_s = addr_d;
      if (last_s) begin
        push_s  = 1'b1;
        state_d = IDLE;
        b_d     = {CNT_W{1'b0}};
        acc_d   = {ACC_W{1'b0}};
      end else begin
        state_d = ACC;
        b_d     = b_eff_s + CNT_ONE;
        acc_d   = sum_s;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Drop detection: a push is lost only if the queue is full and not
  // draining in the same cycle.
  always_comb begin
    pop_s = bus.out_ready && !fifo_empty_s;
    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State, accumulator and sticky status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      b_q     <= {CNT_W{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == ACC);
    end
  end

  pim_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .push_data_i  ({sat_data_s, sat_s, push_addr_s}),
    .pop_i        (pop_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .head_valid_o (bus.out_valid),
    .head_data_o  (head_s)
  );

  assign bus.out_data = head_s[ENTRY_W-1 -: OUT_P];
  assign bus.out_sat  = head_s[ADDR_W];
  assign bus.out_addr = head_s[ADDR_W-1:0];
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pim_shift_accumulator.sv
// ---------------------------------------------------------------------------
// tb_pim_shift_accumulator
// Two instances (OUT_P 16 and 8) share one stimulus stream. A queue-based
// reference model computes each result as a plain weighted sum of the beat
// partials and predicts the result queue, busy and sticky flags per cycle.
// ---------------------------------------------------------------------------
module tb_pim_shift_accumulator;

  localparam int HALF = 4;
  localparam int QCAP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pim_shift_accumulator_if #(.ADDR_W(1), .ADC_P(4), .OUT_P(16)) bus16 ();
  pim_shift_accumulator_if #(.ADDR_W(1), .ADC_P(4), .OUT_P(8))  bus8 ();

  pim_shift_accumulator #(.INPUT_P(8), .ADC_P(4), .DEPTH(1), .OUT_P(16), .FIFO_DEPTH(4))
    dut16 (.clk(clk), .rst(rst), .bus(bus16));
  pim_shift_accumulator #(.INPUT_P(8), .ADC_P(4), .DEPTH(1), .OUT_P(8), .FIFO_DEPTH(4))
    dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int checks = 0;
  int failures = 0;

  typedef struct {
    longint val;
    logic   addr;
  } res_t;

  res_t   mq[$];
  bit     m_acc;
  int     m_nb;
  longint m_val;
  logic   m_addr;
  bit     m_err;
  bit     m_ovf;

  logic       s_valid, s_first, s_addr, s_ready;
  logic [3:0] s_hh, s_hl, s_lh, s_ll;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic f, input logic a,
                        input logic [3:0] hh, input logic [3:0] hl,
                        input logic [3:0] lh, input logic [3:0] ll);
    s_valid = v; s_first = f; s_addr = a;
    s_hh = hh; s_hl = hl; s_lh = lh; s_ll = ll;
    bus16.in_valid = v; bus16.in_first = f; bus16.in_addr = a;
    bus16.psum_hh = hh; bus16.psum_hl = hl; bus16.psum_lh = lh; bus16.psum_ll = ll;
    bus8.in_valid = v;  bus8.in_first = f;  bus8.in_addr = a;
    bus8.psum_hh = hh;  bus8.psum_hl = hl;  bus8.psum_lh = lh;  bus8.psum_ll = ll;
  endtask

  task automatic set_ready(input logic r);
    s_ready = r;
    bus16.out_ready = r;
    bus8.out_ready = r;
  endtask

  function automatic longint sat_val(input longint v, input int op);
    longint lim;
    lim = longint'(1) << op;
    if (v >= lim) return lim - 1;
    return v;
  endfunction

  // Reference: one clock edge of the collector and its result queue.
  task automatic model_step();
    bit pop;
    bit done;
    if (!rst) begin
      mq.delete();
      m_acc = 0; m_nb = 0; m_val = 0; m_err = 0; m_ovf = 0;
      return;
    end
    pop  = (mq.size() != 0) && s_ready;
    done = 0;
    if (s_valid) begin
      if (s_first) begin
        if (m_acc) m_err = 1;
        m_acc = 1; m_nb = 0; m_val = 0; m_addr = s_addr;
      end else if (!m_acc) begin
        m_err = 1;
      end
      if (m_acc) begin
        m_val = m_val + longint'(s_hh) * (longint'(1) << (m_nb + 2 * HALF))
                      + (longint'(s_hl) + longint'(s_lh)) * (longint'(1) << (m_nb + HALF))
                      + longint'(s_ll) * (longint'(1) << m_nb);
        m_nb++;
        if (m_nb == HALF) begin
          done = 1;
          m_acc = 0;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < QCAP) mq.push_back('{val: m_val, addr: m_addr});
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("valid16", bus16.out_valid, mq.size() != 0);
    check_eq("valid8",  bus8.out_valid,  mq.size() != 0);
    check_eq("busy16",  bus16.busy, m_acc);
    check_eq("busy8",   bus8.busy,  m_acc);
    check_eq("err16",   bus16.err, m_err);
    check_eq("err8",    bus8.err,  m_err);
    check_eq("ovf16",   bus16.overflow, m_ovf);
    check_eq("ovf8",    bus8.overflow,  m_ovf);
    if (mq.size() != 0) begin
      check_eq("data16", bus16.out_data, sat_val(mq[0].val, 16));
      check_eq("sat16",  bus16.out_sat,  mq[0].val >= (longint'(1) << 16));
      check_eq("addr16", bus16.out_addr, mq[0].addr);
      check_eq("data8",  bus8.out_data,  sat_val(mq[0].val, 8));
      check_eq("sat8",   bus8.out_sat,   mq[0].val >= (longint'(1) << 8));
      check_eq("addr8",  bus8.out_addr,  mq[0].addr);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  // One full result with the same partials on every beat.
  task automatic result(input logic a, input logic [3:0] hh, input logic [3:0] hl,
                        input logic [3:0] lh, input logic [3:0] ll);
    for (int b = 0; b < HALF; b++) begin
      set_in(1, b == 0, a, hh, hl, lh, ll);
      cycle();
    end
  endtask

  initial begin
    int pops;
    logic v, f;

    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    set_ready(1);
    repeat (2) cycle();
    check_eq("rst_valid", bus16.out_valid, 0);
    check_eq("rst_data",  bus16.out_data, 0);
    check_eq("rst_addr",  bus16.out_addr, 0);
    check_eq("rst_sat",   bus16.out_sat, 0);
    check_eq("rst_busy",  bus16.busy, 0);
    check_eq("rst_err",   bus16.err, 0);
    check_eq("rst_ovf",   bus16.overflow, 0);
    rst = 1'b1;
    idle(1);

    // HH=1 on four beats: 3840, visible one cycle after the last beat.
    for (int b = 0; b < HALF; b++) begin
      set_in(1, b == 0, 0, 1, 0, 0, 0);
      cycle();
      if (b == 0) check_eq("t1_busy_up", bus16.busy, 1);
      if (b == HALF - 2) check_eq("t1_not_early", bus16.out_valid, 0);
    end
    check_eq("t1_valid", bus16.out_valid, 1);
    check_eq("t1_data",  bus16.out_data, 3840);
    check_eq("t1_sat",   bus16.out_sat, 0);
    check_eq("t1_busy_dn", bus16.busy, 0);
    idle(2);

    // LL=15 then back-to-back HL=LH=1.
    result(1, 0, 0, 0, 15);
    check_eq("t2_data_a", bus16.out_data, 225);
    check_eq("t2_addr_a", bus16.out_addr, 1);
    result(0, 0, 1, 1, 0);
    check_eq("t2_data_b", bus16.out_data, 480);
    check_eq("t2_addr_b", bus16.out_addr, 0);
    idle(2);

    // HH=15: clips at OUT_P=8, fits at OUT_P=16.
    result(1, 15, 0, 0, 0);
    check_eq("t3_data8",  bus8.out_data, 255);
    check_eq("t3_sat8",   bus8.out_sat, 1);
    check_eq("t3_data16", bus16.out_data, 57600);
    check_eq("t3_sat16",  bus16.out_sat, 0);
    idle(2);

    // Five results into a stalled queue: fifth dropped.
    set_ready(0);
    repeat (5) result(0, 1, 0, 0, 0);
    check_eq("t4_ovf16", bus16.overflow, 1);
    check_eq("t4_ovf8",  bus8.overflow, 1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    set_ready(1);
    pops = 0;
    repeat (8) begin
      if (bus16.out_valid) begin
        pops++;
        check_eq("t4_pop_data", bus16.out_data, 3840);
      end
      cycle();
    end
    check_eq("t4_pops", pops, 4);

    // Restart on beat 2: err, partial dropped, restarted LL=1 result gives 15.
    set_in(1, 1, 0, 7, 7, 7, 7); cycle();
    set_in(1, 0, 0, 7, 7, 7, 7); cycle();
    set_in(1, 1, 1, 0, 0, 0, 1); cycle();
    check_eq("t5_err", bus16.err, 1);
    for (int b = 1; b < HALF; b++) begin
      set_in(1, 0, 0, 0, 0, 0, 1);
      cycle();
    end
    check_eq("t5_data", bus16.out_data, 15);
    check_eq("t5_addr", bus16.out_addr, 1);
    idle(2);

    // Reset during beat 2 with a result queued.
    set_ready(0);
    result(0, 1, 0, 0, 0);
    set_in(1, 1, 0, 0, 0, 0, 1); cycle();
    set_in(1, 0, 0, 0, 0, 0, 1); cycle();
    set_in(1, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    cycle();
    check_eq("t6_valid", bus16.out_valid, 0);
    check_eq("t6_err",   bus16.err, 0);
    check_eq("t6_ovf",   bus16.overflow, 0);
    check_eq("t6_busy",  bus16.busy, 0);
    rst = 1'b1;
    set_ready(1);
    result(0, 0, 0, 0, 1);
    check_eq("t6_data", bus16.out_data, 15);
    idle(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = m_acc ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      set_in(v, f, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      set_ready($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 249) != 0);
      cycle();
    end
    rst = 1'b1;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
